// File: rtl/core_sequencer.sv
// core_sequencer: multicycle FETCH/DECODE/EXEC/MEM/WRITE step controller
// with stretched EXEC/MEM waits and retired/stall profiling counters.
module core_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             imem_ready,
    input  logic             use_fpu,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             data_in,
    input  logic             data_out,
    input  logic             fpu_done,
    input  logic             dmem_ready,
    input  logic             rx_valid,
    input  logic             tx_ready,
    output logic [2:0]       state,
    output logic             fetch_en,
    output logic             fpu_start,
    output logic             dmem_req,
    output logic             rx_pop,
    output logic             tx_push,
    output logic             pc_write,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             exec_first_q, exec_first_d;
    logic             io_in_q, io_in_d;
    logic             io_out_q, io_out_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic is_in, is_out, is_mem;
    logic leave_exec, stall;
    logic fpu_start_c, rx_pop_c, tx_push_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            exec_first_q <= 1'b1;
            io_in_q      <= 1'b0;
            io_out_q     <= 1'b0;
            instret_q    <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            exec_first_q <= exec_first_d;
            io_in_q      <= io_in_d;
            io_out_q     <= io_out_d;
            instret_q    <= instret_d;
            stall_q      <= stall_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        exec_first_d = exec_first_q;
        io_in_d      = io_in_q;
        io_out_d     = io_out_q;
        instret_d    = instret_q;
        leave_exec   = 1'b0;
        stall        = 1'b0;
        fpu_start_c  = 1'b0;
        rx_pop_c     = 1'b0;
        tx_push_c    = 1'b0;

        // Decode drops data_in/data_out after the first EXEC cycle.
        is_in  = !use_fpu && (exec_first_q ? data_in : io_in_q);
        is_out = !use_fpu && !is_in
                 && (exec_first_q ? data_out : io_out_q);
        is_mem = !use_fpu && !is_in && !is_out
                 && (mem_read || mem_write);

        unique case (state_q)
            S_FETCH: begin
                if (run && imem_ready) begin
                    state_d = S_DECODE;
                end else if (run) begin
                    stall = 1'b1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (exec_first_q) begin
                    io_in_d  = data_in;
                    io_out_d = data_out;
                end
                if (use_fpu) begin
                    fpu_start_c = exec_first_q;
                    leave_exec  = !exec_first_q && fpu_done;
                    stall       = !exec_first_q && !fpu_done;
                end else if (is_in) begin
                    rx_pop_c   = rx_valid;
                    leave_exec = rx_valid;
                    stall      = !rx_valid;
                end else if (is_out) begin
                    tx_push_c  = tx_ready;
                    leave_exec = tx_ready;
                    stall      = !tx_ready;
                end else begin
                    leave_exec = 1'b1;
                end
                if (leave_exec) begin
                    state_d = is_mem ? S_MEM : S_WRITE;
                end
                exec_first_d = leave_exec;
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = S_WRITE;
                end else begin
                    stall = 1'b1;
                end
            end
            S_WRITE: begin
                state_d   = S_FETCH;
                instret_d = instret_q + CNT_W'(1);
            end
            default: state_d = S_FETCH;
        endcase

        stall_d = stall_q + (stall ? CNT_W'(1) : CNT_W'(0));
    end

    assign state        = state_q;
    assign instret      = instret_q;
    assign stall_cycles = stall_q;

    // Reset must silence every strobe, even with run held high.
    assign fetch_en  = !rst && (state_q == S_FETCH) && run;
    assign fpu_start = !rst && fpu_start_c;
    assign dmem_req  = !rst && (state_q == S_MEM);
    assign rx_pop    = !rst && rx_pop_c;
    assign tx_push   = !rst && tx_push_c;
    assign pc_write  = !rst && (state_q == S_WRITE);

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: per-cycle state stream plus
// per-instruction strobe/counter records checked on each pc_write.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run, imem_ready;
    logic        use_fpu, mem_read, mem_write;
    logic        data_in, data_out;
    logic        fpu_done, dmem_ready, rx_valid, tx_ready;

    logic [2:0]  state;
    logic        fetch_en, fpu_start, dmem_req;
    logic        rx_pop, tx_push, pc_write;
    logic [31:0] instret, stall_cycles;

    logic [2:0]  state4;
    logic        fetch_en4, fpu_start4, dmem_req4;
    logic        rx_pop4, tx_push4, pc_write4;
    logic [3:0]  instret4, stall4;

    core_sequencer #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .imem_ready(imem_ready),
        .use_fpu(use_fpu), .mem_read(mem_read), .mem_write(mem_write),
        .data_in(data_in), .data_out(data_out), .fpu_done(fpu_done),
        .dmem_ready(dmem_ready), .rx_valid(rx_valid),
        .tx_ready(tx_ready), .state(state), .fetch_en(fetch_en),
        .fpu_start(fpu_start), .dmem_req(dmem_req), .rx_pop(rx_pop),
        .tx_push(tx_push), .pc_write(pc_write), .instret(instret),
        .stall_cycles(stall_cycles)
    );

    core_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .run(run), .imem_ready(imem_ready),
        .use_fpu(use_fpu), .mem_read(mem_read), .mem_write(mem_write),
        .data_in(data_in), .data_out(data_out), .fpu_done(fpu_done),
        .dmem_ready(dmem_ready), .rx_valid(rx_valid),
        .tx_ready(tx_ready), .state(state4), .fetch_en(fetch_en4),
        .fpu_start(fpu_start4), .dmem_req(dmem_req4), .rx_pop(rx_pop4),
        .tx_push(tx_push4), .pc_write(pc_write4), .instret(instret4),
        .stall_cycles(stall4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          fe;
        int          fs;
        int          rx;
        int          tx;
        int          dm;
        int unsigned ir;
        int unsigned st;
    } exp_t;

    exp_t        eq[$];
    int          sq[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    int unsigned exp_ir = 0;
    int unsigned exp_st = 0;

    task automatic chk(input string nm, input longint act,
                       input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Monitor: owns its own per-instruction tallies.
    int m_cyc, m_fe, m_fs, m_rx, m_tx, m_dm;
    always @(negedge clk) begin
        exp_t e;
        int   es;
        if (!mon_en) begin
            m_cyc = 0; m_fe = 0; m_fs = 0;
            m_rx = 0; m_tx = 0; m_dm = 0;
        end else begin
            m_cyc++;
            m_fe += int'(fetch_en);
            m_fs += int'(fpu_start) + int'(fpu_start4);
            m_rx += int'(rx_pop);
            m_tx += int'(tx_push);
            m_dm += int'(dmem_req);
            if (sq.size() == 0) begin
                chk("state_stream_empty", 1, 0);
            end else begin
                es = sq.pop_front();
                chk("state", int'(state), es);
                chk("state_w4", int'(state4), es);
            end
            if (pc_write) begin
                if (eq.size() == 0) begin
                    chk("write_unexpected", 1, 0);
                end else begin
                    e = eq.pop_front();
                    chk("instr_cycles", m_cyc, e.cyc);
                    chk("fetch_en_cycles", m_fe, e.fe);
                    chk("fpu_start_pulses", m_fs, 2 * e.fs);
                    chk("rx_pop_pulses", m_rx, e.rx);
                    chk("tx_push_pulses", m_tx, e.tx);
                    chk("dmem_req_cycles", m_dm, e.dm);
                    chk("instret", instret, e.ir);
                    chk("stall_cycles", stall_cycles, e.st);
                    chk("instret_w4", instret4, e.ir % 16);
                    chk("stall_w4", stall4, e.st % 16);
                end
                m_cyc = 0; m_fe = 0; m_fs = 0;
                m_rx = 0; m_tx = 0; m_dm = 0;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        use_fpu = 0; mem_read = 0; mem_write = 0;
        data_in = 0; data_out = 0; fpu_done = 0;
        dmem_ready = 0; rx_valid = 0; tx_ready = 0;
    endtask

    // cls: 0 plain, 1 mem, 2 fpu, 3 in, 4 out. w = wait parameter.
    task automatic run_instr(input int cls, input int fw, input int w,
                             input bit spur, input bit din);
        exp_t e;
        int   xl, ml;
        xl = (cls >= 2) ? w + 1 : 1;
        ml = (cls == 1) ? w + 1 : 0;
        exp_st += fw + ((cls == 2) ? w - 1 : (cls == 0) ? 0 : w);
        e.ir  = exp_ir;
        e.st  = exp_st;
        e.cyc = fw + xl + ml + 3;
        e.fe  = fw + 1;
        e.fs  = (cls == 2) ? 1 : 0;
        e.rx  = (cls == 3) ? 1 : 0;
        e.tx  = (cls == 4) ? 1 : 0;
        e.dm  = ml;
        exp_ir++;
        eq.push_back(e);
        repeat (fw + 1) sq.push_back(0);
        sq.push_back(1);
        repeat (xl) sq.push_back(2);
        repeat (ml) sq.push_back(3);
        sq.push_back(4);

        run = 1;
        repeat (fw) begin
            imem_ready = 0;
            nxt();
        end
        imem_ready = 1;
        nxt();
        imem_ready = 1'($urandom_range(0, 1));
        run        = 1'($urandom_range(0, 1));
        use_fpu    = (cls == 2);
        mem_read   = (cls == 1) && $urandom_range(0, 1) == 1;
        mem_write  = (cls == 1) && !mem_read;
        data_in    = (cls == 3) || (cls == 2 && din);
        data_out   = (cls == 4) ||
                     (cls == 2 && $urandom_range(0, 1) == 1);
        if (cls <= 2) begin
            rx_valid = (cls == 2 && din) ? 1'b1
                       : 1'($urandom_range(0, 1));
            tx_ready = 1'($urandom_range(0, 1));
        end
        nxt();
        case (cls)
            0: begin
                fpu_done = spur;
                nxt();
            end
            1: begin
                nxt();
                repeat (w) begin
                    dmem_ready = 0;
                    nxt();
                end
                dmem_ready = 1;
                nxt();
            end
            2: begin
                fpu_done = spur;
                nxt();
                data_in = 0; data_out = 0; fpu_done = 0;
                repeat (w - 1) nxt();
                fpu_done = 1;
                nxt();
            end
            3: begin
                repeat (w) begin
                    rx_valid = 0;
                    tx_ready = 1'($urandom_range(0, 1));
                    nxt();
                    data_in = 0;
                end
                rx_valid = 1;
                nxt();
            end
            default: begin
                repeat (w) begin
                    tx_ready = 0;
                    rx_valid = 1'($urandom_range(0, 1));
                    nxt();
                    data_out = 0;
                end
                tx_ready = 1;
                nxt();
            end
        endcase
        clear_flags();
        nxt();
    endtask

    task automatic rand_instr();
        int cls;
        cls = $urandom_range(0, 4);
        run_instr(cls, $urandom_range(0, 3),
                  (cls == 2) ? $urandom_range(1, 5)
                             : $urandom_range(0, 4),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; run = 1; imem_ready = 1;
        clear_flags();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_fetch_en", fetch_en, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_instret", instret, 0);
        chk("rst_stall", stall_cycles, 0);
        rst = 0;
        mon_en = 1;

        run_instr(0, 0, 0, 0, 0);
        run_instr(2, 0, 3, 1, 0);
        run_instr(1, 0, 2, 0, 0);
        run_instr(3, 0, 2, 0, 0);
        run_instr(4, 0, 2, 0, 0);
        run_instr(2, 1, 1, 0, 1);
        repeat (250) rand_instr();
        mon_en = 0;
        chk("records_left", eq.size(), 0);
        chk("states_left", sq.size(), 0);

        // Abandon a load mid-MEM-wait with a one-cycle reset.
        run = 1; imem_ready = 1;
        nxt();
        imem_ready = 0; mem_read = 1;
        nxt();
        nxt();
        dmem_ready = 0;
        nxt();
        chk("pre_rst_dmem_req", dmem_req, 1);
        rst = 1;
        #1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_instret", instret, 0);
        chk("mid_rst_stall", stall_cycles, 0);
        chk("mid_rst_dmem_req", dmem_req, 0);
        chk("mid_rst_fetch_en", fetch_en, 0);
        nxt();
        rst = 0;
        clear_flags();
        run = 0;
        imem_ready = 1;
        for (int i = 0; i < 10; i++) begin
            nxt();
            chk("park_state", state, 0);
            chk("park_stall", stall_cycles, 0);
            chk("park_fetch_en", fetch_en, 0);
        end

        exp_ir = 0;
        exp_st = 0;
        mon_en = 1;
        repeat (20) rand_instr();
        mon_en = 0;
        chk("records_left_end", eq.size(), 0);
        chk("states_left_end", sq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
